// File: rtl/div_pkg.sv
// Shared types and defaults for the divider front-end (operand entry side).
package div_pkg;

    // Operand-entry controller states.
    typedef enum logic [2:0] {
        ENT_A = 3'd0,
        ENT_B = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SHOW  = 3'd4
    } entry_state_t;

    localparam int N_DIG_DEF   = 2;
    localparam int TIMEOUT_DEF = 50_000_000;

    // Operand width in bits for a given number of hex digits.
    function automatic int op_width(input int n_dig);
        return 4 * n_dig;
    endfunction

endpackage

// File: rtl/captura_operandos_if.sv
// Keypad / divider / display signal bundle for the operand-entry controller.
interface captura_operandos_if #(
    parameter int N_DIG = div_pkg::N_DIG_DEF
);
    localparam int W  = div_pkg::op_width(N_DIG);
    localparam int CW = $clog2(N_DIG) + 1;

    logic [3:0]      tecla_hex;
    logic            tecla_valid;
    logic            div_done;
    logic [W-1:0]    A_bin;
    logic [W-1:0]    B_bin;
    logic            div_start;
    logic            busy;
    logic            err_div0;
    logic [CW-1:0]   digit_cnt;
    logic [2*W-1:0]  disp_val;

    // Keypad decoder, divider and display side.
    modport master (
        output tecla_hex, tecla_valid, div_done,
        input  A_bin, B_bin, div_start, busy, err_div0, digit_cnt, disp_val
    );

    // Operand-entry controller side.
    modport slave (
        input  tecla_hex, tecla_valid, div_done,
        output A_bin, B_bin, div_start, busy, err_div0, digit_cnt, disp_val
    );
endinterface

// File: rtl/inact_timer.sv
// Idle down-counter: reloads on clear, counts while enabled, flags expiry at zero.
module inact_timer #(
    parameter int TIMEOUT = div_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Reload value gives exactly TIMEOUT enabled cycles from a clear to expiry.
    localparam logic [TW-1:0] LOAD_VAL = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: reload on clear, decrement while enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD_VAL;
        end else if (enable_i) begin
            cnt_d = cnt_q - TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT disables expiry altogether.
    assign expire_o = (TIMEOUT != 0) && enable_i && (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/captura_operandos.sv
// Operand-entry controller: assembles A and B from hex keys, launches the divider,
// holds operands until completion and feeds the display.
module captura_operandos
    import div_pkg::*;
#(
    parameter int N_DIG   = N_DIG_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    captura_operandos_if.slave bus
);
    localparam int W  = op_width(N_DIG);
    localparam int CW = $clog2(N_DIG) + 1;
    localparam logic [CW-1:0] ONE_DIG  = CW'(1);
    localparam logic [CW-1:0] LAST_DIG = CW'(N_DIG - 1);

    entry_state_t   state_q, state_d;
    logic [W-1:0]   op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic [2*W-1:0] disp_q, disp_d;

    logic           key_acc_s;
    logic           last_digit_s;
    logic           cnt_en_s;
    logic           timer_clr_s;
    logic           expire_s;
    logic [W-1:0]   op_shift_s;

    // Key acceptance, shifted operand and idle-timer control.
    always_comb begin
        key_acc_s    = bus.tecla_valid &&
                       ((state_q == ENT_A) || (state_q == ENT_B) || (state_q == SHOW));
        last_digit_s = (cnt_q == LAST_DIG);
        op_shift_s   = W'({op_q, bus.tecla_hex});
        cnt_en_s     = ((state_q == ENT_A) && (cnt_q != {CW{1'b0}})) || (state_q == ENT_B);
        // Held in reload whenever not counting so each entry starts a full window.
        timer_clr_s  = key_acc_s || !cnt_en_s;
    end

    inact_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_inact_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clr_s),
        .enable_i (cnt_en_s),
        .expire_o (expire_s)
    );

    // Next-state, operand and output computation.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ENT_A: begin
                if (key_acc_s) begin
                    err_d = 1'b0;
                    if (last_digit_s) begin
                        a_d     = op_shift_s;
                        op_d    = {W{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        state_d = ENT_B;
                    end else begin
                        op_d  = op_shift_s;
                        cnt_d = cnt_q + ONE_DIG;
                    end
                end else if (expire_s) begin
                    op_d    = {W{1'b0}};
                    a_d     = {W{1'b0}};
                    b_d     = {W{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ENT_A;
                end else begin
                    state_d = ENT_A;
                end
            end
            ENT_B: begin
                if (key_acc_s) begin
                    err_d = 1'b0;
                    if (last_digit_s) begin
                        op_d  = {W{1'b0}};
                        cnt_d = {CW{1'b0}};
                        if (op_shift_s != {W{1'b0}}) begin
                            b_d     = op_shift_s;
                            state_d = START;
                        end else begin
                            // Divide by zero: drop both operands, never start.
                            err_d   = 1'b1;
                            a_d     = {W{1'b0}};
                            b_d     = {W{1'b0}};
                            state_d = ENT_A;
                        end
                    end else begin
                        op_d  = op_shift_s;
                        cnt_d = cnt_q + ONE_DIG;
                    end
                end else if (expire_s) begin
                    op_d    = {W{1'b0}};
                    a_d     = {W{1'b0}};
                    b_d     = {W{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ENT_A;
                end else begin
                    state_d = ENT_B;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.div_done) begin
                    state_d = SHOW;
                end else begin
                    state_d = WAIT;
                end
            end
            SHOW: begin
                if (key_acc_s) begin
                    // The waking key is the first digit of the next dividend.
                    a_d     = {W{1'b0}};
                    b_d     = {W{1'b0}};
                    err_d   = 1'b0;
                    op_d    = W'(bus.tecla_hex);
                    cnt_d   = ONE_DIG;
                    state_d = ENT_A;
                end else begin
                    state_d = SHOW;
                end
            end
            default: begin
                state_d = ENT_A;
                op_d    = {W{1'b0}};
                a_d     = {W{1'b0}};
                b_d     = {W{1'b0}};
                err_d   = 1'b0;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        // Outputs are derived from next-state values so they register in step with state.
        start_d = (state_d == START);
        busy_d  = (state_d == START) || (state_d == WAIT);
        case (state_d)
            ENT_A:   disp_d = {{W{1'b0}}, op_d};
            ENT_B:   disp_d = {a_d, op_d};
            default: disp_d = {a_d, b_d};
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ENT_A;
            op_q    <= {W{1'b0}};
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            err_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            disp_q  <= {(2*W){1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.A_bin     = a_q;
    assign bus.B_bin     = b_q;
    assign bus.div_start = start_q;
    assign bus.busy      = busy_q;
    assign bus.err_div0  = err_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.disp_val  = disp_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed scenarios plus randomized keys against a
// digit-queue reference model.
module tb_captura_operandos;
    localparam int ND = 2;
    localparam int TO = 100;

    logic clk;
    logic rst;
    int   total  = 0;
    int   bad    = 0;
    int   starts = 0;

    // Reference model: phase 0 = entering A, 1 = entering B, 2 = start pulse,
    // 3 = waiting for divider, 4 = showing result.
    int   m_phase;
    int   m_digs[$];
    int   m_a;
    int   m_b;
    bit   m_err;
    int   m_idle;

    captura_operandos_if #(.N_DIG(ND)) bus ();

    captura_operandos #(
        .N_DIG   (ND),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.div_start === 1'b1) starts = starts + 1;
    end

    function automatic int m_partial();
        int v = 0;
        foreach (m_digs[i]) v = v * 16 + m_digs[i];
        return v;
    endfunction

    function automatic logic [15:0] m_disp();
        case (m_phase)
            0:       return 16'(m_partial());
            1:       return 16'((m_a << 8) | m_partial());
            default: return 16'((m_a << 8) | m_b);
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_digs.delete();
        m_a = 0;
        m_b = 0;
        m_err = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_step(input bit v, input int h, input bit d);
        bit acc;
        bit counting;
        int val;
        acc      = v && (m_phase == 0 || m_phase == 1 || m_phase == 4);
        counting = (m_phase == 0 && m_digs.size() > 0) || m_phase == 1;
        if (m_phase == 0 || m_phase == 1) begin
            if (acc) begin
                m_err = 1'b0;
                m_digs.push_back(h);
                if (m_digs.size() == ND) begin
                    val = m_partial();
                    m_digs.delete();
                    if (m_phase == 0) begin
                        m_a = val;
                        m_phase = 1;
                    end else if (val != 0) begin
                        m_b = val;
                        m_phase = 2;
                    end else begin
                        m_err = 1'b1;
                        m_a = 0;
                        m_b = 0;
                        m_phase = 0;
                    end
                end
            end else if (counting && m_idle == TO - 1) begin
                m_digs.delete();
                m_a = 0;
                m_b = 0;
                m_phase = 0;
            end
        end else if (m_phase == 2) begin
            m_phase = 3;
        end else if (m_phase == 3) begin
            if (d) m_phase = 4;
        end else if (acc) begin
            m_a = 0;
            m_b = 0;
            m_err = 1'b0;
            m_digs.delete();
            m_digs.push_back(h);
            m_phase = 0;
        end
        if (acc) m_idle = 0;
        else if (counting) m_idle = (m_idle == TO - 1) ? 0 : m_idle + 1;
        else m_idle = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, release inputs after it.
    task automatic step(input bit v, input logic [3:0] h, input bit d);
        bus.tecla_valid = v;
        bus.tecla_hex   = h;
        bus.div_done    = d;
        @(posedge clk);
        model_step(v, int'(h), d);
        #1;
        bus.tecla_valid = 1'b0;
        bus.div_done    = 1'b0;
    endtask

    task automatic key(input logic [3:0] h);
        step(1'b1, h, 1'b0);
        step(1'b0, 4'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #3;
        total++; if (bus.A_bin !== 8'h00) begin bad++; $display("FAIL reset_A got=%h want=00", bus.A_bin); end
        total++; if (bus.B_bin !== 8'h00) begin bad++; $display("FAIL reset_B got=%h want=00", bus.B_bin); end
        total++; if (bus.div_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus.div_start); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.err_div0 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_div0); end
        total++; if (bus.digit_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.digit_cnt); end
        total++; if (bus.disp_val !== 16'h0000) begin bad++; $display("FAIL reset_disp got=%h want=0000", bus.disp_val); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_normal();
        int s0;
        do_reset();
        s0 = starts;
        key(4'h4); key(4'h5); key(4'h0);
        step(1'b1, 4'h7, 1'b0);
        total++; if (bus.div_start !== 1'b1) begin bad++; $display("FAIL normal_start got=%b want=1", bus.div_start); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL normal_busy got=%b want=1", bus.busy); end
        total++; if (bus.A_bin !== 8'h45) begin bad++; $display("FAIL normal_A got=%h want=45", bus.A_bin); end
        total++; if (bus.B_bin !== 8'h07) begin bad++; $display("FAIL normal_B got=%h want=07", bus.B_bin); end
        step(1'b0, 4'h0, 1'b0);
        total++; if (bus.div_start !== 1'b0) begin bad++; $display("FAIL normal_start_end got=%b want=0", bus.div_start); end
        idle(6);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL normal_wait_busy got=%b want=1", bus.busy); end
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL normal_pulses got=%0d want=1", starts - s0); end
        step(1'b0, 4'h0, 1'b1);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL normal_show_busy got=%b want=0", bus.busy); end
        total++; if (bus.disp_val !== 16'h4507) begin bad++; $display("FAIL normal_disp got=%h want=4507", bus.disp_val); end
    endtask

    task automatic test_div0();
        int s0;
        do_reset();
        s0 = starts;
        key(4'h7); key(4'hE); key(4'h0);
        step(1'b1, 4'h0, 1'b0);
        total++; if (bus.err_div0 !== 1'b1) begin bad++; $display("FAIL div0_err got=%b want=1", bus.err_div0); end
        total++; if (bus.A_bin !== 8'h00) begin bad++; $display("FAIL div0_A got=%h want=00", bus.A_bin); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL div0_busy got=%b want=0", bus.busy); end
        total++; if (bus.digit_cnt !== 2'd0) begin bad++; $display("FAIL div0_cnt got=%0d want=0", bus.digit_cnt); end
        idle(3);
        total++; if (starts - s0 !== 0) begin bad++; $display("FAIL div0_pulses got=%0d want=0", starts - s0); end
        step(1'b1, 4'h3, 1'b0);
        total++; if (bus.err_div0 !== 1'b0) begin bad++; $display("FAIL div0_clear got=%b want=0", bus.err_div0); end
        total++; if (bus.digit_cnt !== 2'd1) begin bad++; $display("FAIL div0_next_cnt got=%0d want=1", bus.digit_cnt); end
        total++; if (bus.disp_val !== 16'h0003) begin bad++; $display("FAIL div0_next_disp got=%h want=0003", bus.disp_val); end
    endtask

    task automatic test_wait_keys();
        do_reset();
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'hA, 1'b0);
        total++; if (bus.A_bin !== 8'h12) begin bad++; $display("FAIL wait_A got=%h want=12", bus.A_bin); end
        total++; if (bus.B_bin !== 8'h34) begin bad++; $display("FAIL wait_B got=%h want=34", bus.B_bin); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wait_busy got=%b want=1", bus.busy); end
        total++; if (bus.digit_cnt !== 2'd0) begin bad++; $display("FAIL wait_cnt got=%0d want=0", bus.digit_cnt); end
        step(1'b1, 4'h5, 1'b1);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%b want=0", bus.busy); end
        total++; if (bus.digit_cnt !== 2'd0) begin bad++; $display("FAIL done_key_dropped got=%0d want=0", bus.digit_cnt); end
        total++; if (bus.disp_val !== 16'h1234) begin bad++; $display("FAIL done_disp got=%h want=1234", bus.disp_val); end
    endtask

    task automatic test_show_restart();
        step(1'b1, 4'h2, 1'b0);
        total++; if (bus.A_bin !== 8'h00) begin bad++; $display("FAIL show_A got=%h want=00", bus.A_bin); end
        total++; if (bus.B_bin !== 8'h00) begin bad++; $display("FAIL show_B got=%h want=00", bus.B_bin); end
        total++; if (bus.disp_val !== 16'h0002) begin bad++; $display("FAIL show_disp got=%h want=0002", bus.disp_val); end
        total++; if (bus.digit_cnt !== 2'd1) begin bad++; $display("FAIL show_cnt got=%0d want=1", bus.digit_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1'b1, 4'h9, 1'b0);
        idle(99);
        total++; if (bus.digit_cnt !== 2'd1) begin bad++; $display("FAIL to_kept_cnt got=%0d want=1", bus.digit_cnt); end
        step(1'b0, 4'h0, 1'b0);
        total++; if (bus.digit_cnt !== 2'd0) begin bad++; $display("FAIL to_expired_cnt got=%0d want=0", bus.digit_cnt); end
        total++; if (bus.disp_val !== 16'h0000) begin bad++; $display("FAIL to_expired_disp got=%h want=0000", bus.disp_val); end
        step(1'b1, 4'h9, 1'b0);
        idle(99);
        total++; if (bus.disp_val !== 16'h0009) begin bad++; $display("FAIL to_partial_disp got=%h want=0009", bus.disp_val); end
        step(1'b1, 4'h5, 1'b0);
        total++; if (bus.A_bin !== 8'h95) begin bad++; $display("FAIL to_key_wins got=%h want=95", bus.A_bin); end
        idle(99);
        total++; if (bus.A_bin !== 8'h95) begin bad++; $display("FAIL to_entb_kept got=%h want=95", bus.A_bin); end
        step(1'b0, 4'h0, 1'b0);
        total++; if (bus.A_bin !== 8'h00) begin bad++; $display("FAIL to_entb_A got=%h want=00", bus.A_bin); end
        total++; if (bus.disp_val !== 16'h0000) begin bad++; $display("FAIL to_entb_disp got=%h want=0000", bus.disp_val); end
    endtask

    task automatic test_reset_wait();
        int s0;
        do_reset();
        key(4'h1); key(4'h1); key(4'h2); key(4'h2);
        idle(3);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstw_busy got=%b want=0", bus.busy); end
        total++; if (bus.A_bin !== 8'h00) begin bad++; $display("FAIL rstw_A got=%h want=00", bus.A_bin); end
        total++; if (bus.B_bin !== 8'h00) begin bad++; $display("FAIL rstw_B got=%h want=00", bus.B_bin); end
        total++; if (bus.disp_val !== 16'h0000) begin bad++; $display("FAIL rstw_disp got=%h want=0000", bus.disp_val); end
        total++; if (bus.div_start !== 1'b0) begin bad++; $display("FAIL rstw_start got=%b want=0", bus.div_start); end
        @(negedge clk);
        rst = 1'b1;
        s0 = starts;
        key(4'hF); key(4'hF); key(4'h0); key(4'h1);
        idle(4);
        total++; if (starts - s0 !== 1) begin bad++; $display("FAIL rstw_pulses got=%0d want=1", starts - s0); end
        total++; if (bus.A_bin !== 8'hFF) begin bad++; $display("FAIL rstw_A2 got=%h want=FF", bus.A_bin); end
        total++; if (bus.B_bin !== 8'h01) begin bad++; $display("FAIL rstw_B2 got=%h want=01", bus.B_bin); end
    endtask

    task automatic test_random();
        bit         v;
        bit         d;
        logic [3:0] h;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = (i >= 300 && i < 420) ? 1'b0 : ($urandom_range(0, 2) == 0);
            h = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            step(v, h, d);
            total++; if (bus.A_bin !== 8'(m_a)) begin bad++; $display("FAIL rnd_A i=%0d got=%h want=%h", i, bus.A_bin, 8'(m_a)); end
            total++; if (bus.B_bin !== 8'(m_b)) begin bad++; $display("FAIL rnd_B i=%0d got=%h want=%h", i, bus.B_bin, 8'(m_b)); end
            total++; if (bus.div_start !== (m_phase == 2)) begin bad++; $display("FAIL rnd_start i=%0d got=%b want=%b", i, bus.div_start, (m_phase == 2)); end
            total++; if (bus.busy !== (m_phase == 2 || m_phase == 3)) begin bad++; $display("FAIL rnd_busy i=%0d got=%b want=%b", i, bus.busy, (m_phase == 2 || m_phase == 3)); end
            total++; if (bus.err_div0 !== m_err) begin bad++; $display("FAIL rnd_err i=%0d got=%b want=%b", i, bus.err_div0, m_err); end
            total++; if (bus.digit_cnt !== 2'(m_digs.size())) begin bad++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, bus.digit_cnt, m_digs.size()); end
            total++; if (bus.disp_val !== m_disp()) begin bad++; $display("FAIL rnd_disp i=%0d got=%h want=%h", i, bus.disp_val, m_disp()); end
        end
    endtask

    initial begin
        bus.tecla_valid = 1'b0;
        bus.tecla_hex   = 4'h0;
        bus.div_done    = 1'b0;
        test_reset();
        test_normal();
        test_div0();
        test_wait_keys();
        test_show_restart();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
